mem_port_arbiter: RTL and testbench

//  Shares the single main-memory port between the instruction-cache miss path (I)
//  and the data-cache miss/writeback path (D). Registers the granted request and

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single main-memory port between the instruction-cache miss path
// (I) and the data-cache miss/writeback path (D). The granted request is
// latched into the M_* registers and held until memory completes. Each
// requester then sees one RESP cycle with its busywait low.
//
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin between I and D when both request in IDLE
//   undefined : fixed priority, D always wins over I
//
// Ports
//   CLK, RESET               clock (rising edge), async active-high reset
//   I_READ, I_ADDR           I-cache line fill request
//   I_READDATA, I_BUSYWAIT   fill data (registered), request-not-complete
//   D_READ, D_WRITE          D-cache fill / writeback request
//   D_ADDR, D_WRITEDATA      D-cache block address, writeback data
//   D_READDATA, D_BUSYWAIT   fill data (registered), request-not-complete
//   M_READ, M_WRITE          memory strobes (registered)
//   M_ADDR, M_WRITEDATA      memory address / write data (registered)
//   M_READDATA, M_BUSYWAIT   memory response; done in first strobed cycle
//                            where M_BUSYWAIT is 0
//   GRANT                    {D,I} one-hot owner, 2'b00 when idle
//   dbg_state                current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Handshake: a requester raises its request and holds address/data until its
// busywait falls. Busywait is high in the same cycle the request appears and
// low for exactly the RESP cycle of that requester's transaction. The latched
// copy is used, so input changes after the grant are ignored.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT,
  output logic [1:0]        GRANT,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_I = 2'b01;
  localparam logic [1:0] GRANT_D = 2'b10;

  state_t state;
  logic   d_req;
  logic   pick_d;

  assign dbg_state = state;

  // A simultaneous read and write from D is treated as a write.
  assign d_req = D_READ | D_WRITE;

`ifdef ARB_RR_EN
  // last_d: 1 when D was the most recent owner; reset value means "I".
  logic last_d;
  assign pick_d = d_req && (!I_READ || !last_d);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_ADDR      <= '0;
      M_WRITEDATA <= '0;
      I_READDATA  <= '0;
      D_READDATA  <= '0;
      GRANT       <= 2'b00;
`ifdef ARB_RR_EN
      last_d      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (d_req || I_READ) begin
            if (pick_d) begin
              GRANT   <= GRANT_D;
              M_ADDR  <= D_ADDR;
              M_WRITE <= D_WRITE;
              M_READ  <= !D_WRITE;
              if (D_WRITE) begin
                M_WRITEDATA <= D_WRITEDATA;
              end
            end else begin
              GRANT   <= GRANT_I;
              M_ADDR  <= I_ADDR;
              M_WRITE <= 1'b0;
              M_READ  <= 1'b1;
            end
`ifdef ARB_RR_EN
            last_d <= pick_d;
`endif
            state <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (!M_BUSYWAIT) begin
            // Writes leave the owner's read-data register untouched.
            if (M_READ) begin
              if (GRANT == GRANT_D) begin
                D_READDATA <= M_READDATA;
              end else begin
                I_READDATA <= M_READDATA;
              end
            end
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            state   <= ST_RESP;
          end
        end

        ST_RESP: begin
          // GRANT stays valid through RESP so busywait can key off it.
          GRANT <= 2'b00;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational: a dropped request reads 0 even while its access completes.
  assign I_BUSYWAIT = I_READ && !((state == ST_RESP) && (GRANT == GRANT_I));
  assign D_BUSYWAIT = d_req  && !((state == ST_RESP) && (GRANT == GRANT_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter: a memory model with a programmable wait count, a
// table of single-requester transactions, and hand-written sequences for
// contention, reset mid-transaction and a request dropped during BUSY. Every
// memory access is compared against an expected queue filled when the
// stimulus is driven.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int EW = 2 + 1 + AW + DW;  // {grant, write, addr, wdata}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          m_read;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_writedata;
  logic [DW-1:0] m_readdata;
  logic          m_busywait;
  logic [1:0]    grant;
  logic [1:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RESET(reset),
    .I_READ(i_read), .I_ADDR(i_addr), .I_READDATA(i_readdata), .I_BUSYWAIT(i_busywait),
    .D_READ(d_read), .D_WRITE(d_write), .D_ADDR(d_addr), .D_WRITEDATA(d_wdata),
    .D_READDATA(d_readdata), .D_BUSYWAIT(d_busywait),
    .M_READ(m_read), .M_WRITE(m_write), .M_ADDR(m_addr), .M_WRITEDATA(m_writedata),
    .M_READDATA(m_readdata), .M_BUSYWAIT(m_busywait),
    .GRANT(grant), .dbg_state(dbg_state)
  );

  // memory model: busy for mem_wait strobed cycles, then completes
  int            mem_wait = 0;
  logic [DW-1:0] mem_data = '0;
  int            strobe_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) strobe_cnt <= 0;
    else if (m_read || m_write) strobe_cnt <= strobe_cnt + 1;
    else strobe_cnt <= 0;
  end
  assign m_busywait = (strobe_cnt < mem_wait);
  assign m_readdata = mem_data;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (m_read || m_write) && !m_busywait) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_access: got grant %0b addr %0h expected no access", grant, m_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("acc_grant", 160'(grant), 160'(mon_e[EW-1 -: 2]));
        check("acc_write", 160'(m_write), 160'(mon_e[AW+DW]));
        check("acc_read", 160'(m_read), 160'(!mon_e[AW+DW]));
        check("acc_addr", 160'(m_addr), 160'(mon_e[AW+DW-1 -: AW]));
        if (mon_e[AW+DW]) check("acc_wdata", 160'(m_writedata), 160'(mon_e[DW-1:0]));
      end
    end
  end

  task automatic push_exp(input logic [1:0] g, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
    exp_q.push_back({g, w, a, wd});
  endtask

  // waits (bounded) until the FSM is in RESP, sampled at negedge
  task automatic wait_resp(output bit ok);
    int n = 0;
    while (dbg_state != 2'd2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = (dbg_state == 2'd2);
  endtask

  // table of single-requester vectors
  typedef struct {
    logic          i_read;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    int            nwait;
    logic [DW-1:0] mdata;
    logic          chg;
    logic [1:0]    exp_grant;
    logic          exp_write;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  logic [DW-1:0] mi = '0;
  logic [DW-1:0] md = '0;
  logic          last_d_m;
  logic [1:0]    g_m;
  int  cyc;
  bit  done;
  bit  ok;
  int  hold_err;

  initial begin : main
    vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000040, 28'h0, 128'h0, 3, {16{8'hA5}}, 1'b0, 2'b01, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h0000100, 128'h1234, 2, {16{8'h77}}, 1'b0, 2'b10, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h0ABCDEF, 128'h0, 0,
                {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 2'b10, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'hFFFFFFF, {4{32'hDEADBEEF}}, 1, {16{8'h3C}}, 1'b0, 2'b10, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 28'h0000123, 28'h0, 128'h0, 4, {16{8'hC3}}, 1'b1, 2'b01, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 28'h0FFFFFF, 28'h0, 128'h0, $urandom_range(0, 5),
                {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 2'b01, 1'b0};

    // reset state
    @(negedge clk);
    check("rst_grant", 160'(grant), 160'(0));
    check("rst_strobes", 160'({m_write, m_read}), 160'(0));
    check("rst_maddr", 160'(m_addr), 160'(0));
    check("rst_mwdata", 160'(m_writedata), 160'(0));
    check("rst_i_rdata", 160'(i_readdata), 160'(0));
    check("rst_d_rdata", 160'(d_readdata), 160'(0));
    check("rst_state", 160'(dbg_state), 160'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_busywait", 160'({d_busywait, i_busywait}), 160'(0));

    // contention: both requesting for 4 transactions, then D drops
    last_d_m = 1'b0;
    mem_wait = 1;
    mem_data = {8{16'h5A5A}};
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 28'h0000080;
    d_read = 1'b1; d_addr = 28'h0000200;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      g_m = last_d_m ? 2'b01 : 2'b10;
`else
      g_m = 2'b10;
`endif
      last_d_m = g_m[1];
      push_exp(g_m, 1'b0, g_m[1] ? 28'h0000200 : 28'h0000080, '0);
    end
    @(negedge clk);
    check("both_c0_busywait", 160'({d_busywait, i_busywait}), 160'(2'b11));
    hold_err = 0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (i_busywait != !(dbg_state == 2'd2 && grant == 2'b01)) hold_err++;
      if (d_busywait != !(dbg_state == 2'd2 && grant == 2'b10)) hold_err++;
    end
    check("both_4_done", 160'(exp_q.size()), 160'(0));
    check("both_busywait_hold", 160'(hold_err), 160'(0));
    push_exp(2'b01, 1'b0, 28'h0000080, '0);
    @(posedge clk); #1 d_read = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    wait_resp(ok);
    check("both_i_resp", 160'(ok), 160'(1));
    check("both_i_grant", 160'(grant), 160'(2'b01));
    check("both_i_bw", 160'(i_busywait), 160'(0));
    mi = mem_data;
    md = mem_data;
    check("both_i_rdata", 160'(i_readdata), 160'(mi));
    check("both_d_rdata", 160'(d_readdata), 160'(md));
    @(posedge clk); #1 i_read = 1'b0;

    // table-driven single transactions
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      mem_wait = v.nwait;
      mem_data = v.mdata;
      @(posedge clk); #1;
      i_read = v.i_read; i_addr = v.i_addr;
      d_read = v.d_read; d_write = v.d_write; d_addr = v.d_addr; d_wdata = v.d_wdata;
      push_exp(v.exp_grant, v.exp_write, v.exp_grant[1] ? v.d_addr : v.i_addr,
               v.exp_write ? v.d_wdata : '0);
      @(negedge clk);
      check("c0_busywait", 160'(v.exp_grant[1] ? d_busywait : i_busywait), 160'(1));
      check("c0_grant", 160'(grant), 160'(0));
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          check("c1_strobe", 160'({m_write, m_read}), 160'(v.exp_write ? 2'b10 : 2'b01));
          check("c1_grant", 160'(grant), 160'(v.exp_grant));
          if (v.chg) i_addr = 28'h0000FFF;
        end
        if (!(v.exp_grant[1] ? d_busywait : i_busywait)) done = 1'b1;
      end
      check("latency", 160'(cyc), 160'(v.nwait + 2));
      check("resp_state", 160'(dbg_state), 160'(2));
      check("resp_grant", 160'(grant), 160'(v.exp_grant));
      check("resp_strobe", 160'({m_write, m_read}), 160'(0));
      if (!v.exp_write) begin
        if (v.exp_grant[1]) md = v.mdata;
        else mi = v.mdata;
      end
      check("resp_i_rdata", 160'(i_readdata), 160'(mi));
      check("resp_d_rdata", 160'(d_readdata), 160'(md));
      @(posedge clk); #1;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      check("after_grant", 160'(grant), 160'(0));
      check("after_state", 160'(dbg_state), 160'(0));
    end

    // request dropped during BUSY: access still completes and data lands
    mem_wait = 3;
    mem_data = {4{32'hCAFEF00D}};
    @(posedge clk); #1;
    d_read = 1'b1; d_addr = 28'h0000555;
    push_exp(2'b10, 1'b0, 28'h0000555, '0);
    @(negedge clk);
    @(negedge clk);
    d_read = 1'b0;
    #1 check("drop_bw", 160'(d_busywait), 160'(0));
    wait_resp(ok);
    check("drop_resp", 160'(ok), 160'(1));
    check("drop_resp_bw", 160'(d_busywait), 160'(0));
    md = mem_data;
    check("drop_d_rdata", 160'(d_readdata), 160'(md));
    @(negedge clk);
    check("drop_idle", 160'(grant), 160'(0));

    // reset pulse mid-BUSY, held request re-granted afterwards
    mem_wait = 5;
    mem_data = {16{8'h96}};
    @(posedge clk); #1;
    i_read = 1'b1; i_addr = 28'h0000333;
    push_exp(2'b01, 1'b0, 28'h0000333, '0);
    @(negedge clk);
    @(negedge clk);
    check("prerst_mread", 160'(m_read), 160'(1));
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async_mread", 160'(m_read), 160'(0));
    check("rst_async_grant", 160'(grant), 160'(0));
    check("rst_async_state", 160'(dbg_state), 160'(0));
    check("rst_async_bw", 160'(i_busywait), 160'(1));
    mi = '0;
    md = '0;
    check("rst_async_d_rdata", 160'(d_readdata), 160'(md));
    push_exp(2'b01, 1'b0, 28'h0000333, '0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("regrant", 160'(grant), 160'(2'b01));
    wait_resp(ok);
    check("regrant_resp", 160'(ok), 160'(1));
    mi = mem_data;
    check("regrant_i_rdata", 160'(i_readdata), 160'(mi));
    @(posedge clk); #1 i_read = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", 160'(exp_q.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected end of test");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
